// File: rtl/traffic_pkg.sv
// Shared codes and constants for the traffic light phase scheduler.
// Latency: n/a (types, constants and a constant helper only).
// Backpressure: n/a.
package traffic_pkg;

    // Phase-type codes presented by the light FSM
    localparam logic [1:0] PH_RED    = 2'd0;
    localparam logic [1:0] PH_PG     = 2'd1;
    localparam logic [1:0] PH_EG     = 2'd2;
    localparam logic [1:0] PH_YELLOW = 2'd3;

    // Lane indices, also the bit positions of the pedestrian vectors
    localparam logic [1:0] LANE_NS1 = 2'd0;
    localparam logic [1:0] LANE_NS2 = 2'd1;
    localparam logic [1:0] LANE_EW1 = 2'd2;
    localparam logic [1:0] LANE_EW2 = 2'd3;

    // Default dwell and walk lengths in cycles
    localparam int unsigned DEF_CNT_W    = 16;
    localparam int unsigned DEF_RED_CYC  = 2;
    localparam int unsigned DEF_PG_CYC   = 20;
    localparam int unsigned DEF_EG_CYC   = 10;
    localparam int unsigned DEF_Y_CYC    = 4;
    localparam int unsigned DEF_WALK_CYC = 15;

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_COUNT = 2'd1,
        ST_WALK  = 2'd2
    } sched_state_t;

    // Counter preload for an N-cycle interval; a length of 0 behaves as 1
    function automatic int unsigned dwell_load_val(input int unsigned cyc);
        return (cyc == 0) ? 0 : cyc - 1;
    endfunction

endpackage

// File: rtl/dwell_counter.sv
// Loadable down-counter that stops at zero, with a freeze input and zero flag.
// Latency: load and decrement take effect on the next clock edge.
// Backpressure: freeze holds the count; load overrides freeze.
module dwell_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             freeze,
    output logic             zero
);

    logic [CNT_W-1:0] cnt;

    // Load has priority; otherwise count down and park at zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (!freeze && cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/traffic_phase_scheduler.sv
// Dwell sequencer for the light FSM: times each phase and inserts pedestrian walks on RED.
// Latency: a phase lasts 1 load cycle + dwell cycles (+ walk cycles on a served RED); advance is combinational.
// Backpressure: hold freezes counting and suppresses advance except in the load cycle.
module traffic_phase_scheduler
    import traffic_pkg::*;
#(
    parameter int unsigned CNT_W    = DEF_CNT_W,
    parameter int unsigned RED_CYC  = DEF_RED_CYC,
    parameter int unsigned PG_CYC   = DEF_PG_CYC,
    parameter int unsigned EG_CYC   = DEF_EG_CYC,
    parameter int unsigned Y_CYC    = DEF_Y_CYC,
    parameter int unsigned WALK_CYC = DEF_WALK_CYC
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] phase_type,
    input  logic [1:0] lane,
    input  logic [3:0] ped_req,
    input  logic       hold,
    output logic       advance,
    output logic [3:0] ped_walk,
    output logic [3:0] ped_pending
);

    localparam logic [CNT_W-1:0] RED_LD  = CNT_W'(dwell_load_val(RED_CYC));
    localparam logic [CNT_W-1:0] PG_LD   = CNT_W'(dwell_load_val(PG_CYC));
    localparam logic [CNT_W-1:0] EG_LD   = CNT_W'(dwell_load_val(EG_CYC));
    localparam logic [CNT_W-1:0] Y_LD    = CNT_W'(dwell_load_val(Y_CYC));
    localparam logic [CNT_W-1:0] WALK_LD = CNT_W'(dwell_load_val(WALK_CYC));

    sched_state_t     state, state_nxt;
    logic [CNT_W-1:0] dwell_ld;
    logic             dwell_zero, walk_zero;
    logic             go_walk;
    logic [3:0]       lane_oh;

    assign lane_oh = 4'b0001 << lane;

    // Preload value for the phase currently presented by the light FSM
    always_comb begin
        dwell_ld = Y_LD;
        case (phase_type)
            PH_RED:  dwell_ld = RED_LD;
            PH_PG:   dwell_ld = PG_LD;
            PH_EG:   dwell_ld = EG_LD;
            default: dwell_ld = Y_LD;
        endcase
    end

    dwell_counter #(.CNT_W(CNT_W)) u_dwell (
        .clk      (clk),
        .rst      (rst),
        .load     (state == ST_LOAD),
        .load_val (dwell_ld),
        .freeze   (hold || state != ST_COUNT),
        .zero     (dwell_zero)
    );

    dwell_counter #(.CNT_W(CNT_W)) u_walk (
        .clk      (clk),
        .rst      (rst),
        .load     (go_walk),
        .load_val (WALK_LD),
        .freeze   (hold || state != ST_WALK),
        .zero     (walk_zero)
    );

    // Scheduler state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_LOAD;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state, walk entry and advance; expiry decisions wait out any hold
    always_comb begin
        state_nxt = state;
        advance   = 1'b0;
        go_walk   = 1'b0;
        case (state)
            ST_LOAD: begin
                state_nxt = ST_COUNT;
            end
            ST_COUNT: begin
                if (!hold && dwell_zero) begin
                    if (phase_type == PH_RED && ped_pending[lane]) begin
                        go_walk   = 1'b1;
                        state_nxt = ST_WALK;
                    end else begin
                        advance   = 1'b1;
                        state_nxt = ST_LOAD;
                    end
                end
            end
            ST_WALK: begin
                if (!hold && walk_zero) begin
                    advance   = 1'b1;
                    state_nxt = ST_LOAD;
                end
            end
            default: begin
                state_nxt = ST_LOAD;
            end
        endcase
    end

    // Walk indication: lit for the whole walk interval, including held cycles
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ped_walk <= '0;
        end else if (go_walk) begin
            ped_walk <= lane_oh;
        end else if (state == ST_WALK && advance) begin
            ped_walk <= '0;
        end
    end

    // Sticky requests; a new request in the serve cycle keeps the bit set
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ped_pending <= '0;
        end else begin
            ped_pending <= (ped_pending & ~(go_walk ? lane_oh : 4'b0000)) | ped_req;
        end
    end

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Bench for traffic_phase_scheduler: positional phase model checked every cycle plus literal timings.
// Latency: n/a.
// Backpressure: n/a.
module tb_traffic_phase_scheduler;
    import traffic_pkg::*;

    localparam int RED_C  = 2;
    localparam int PG_C   = 20;
    localparam int EG_C   = 10;
    localparam int Y_C    = 4;
    localparam int WALK_C = 15;

    logic       clk;
    logic       rst;
    logic [1:0] phase_type;
    logic [1:0] lane;
    logic [3:0] ped_req;
    logic       hold;
    logic       advance;
    logic [3:0] ped_walk;
    logic [3:0] ped_pending;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    // Model: position within the current phase and the lane being walked (-1 none)
    int         m_pos  = 0;
    int         m_walk = -1;
    logic [3:0] m_pend = 4'b0;

    logic       dut_adv_prev = 1'b0;
    int         adv_t = 0;
    int         walk_cycles = 0;
    logic [3:0] walk_or = 4'b0;

    traffic_phase_scheduler #(
        .CNT_W    (16),
        .RED_CYC  (RED_C),
        .PG_CYC   (PG_C),
        .EG_CYC   (EG_C),
        .Y_CYC    (Y_C),
        .WALK_CYC (WALK_C)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .phase_type  (phase_type),
        .lane        (lane),
        .ped_req     (ped_req),
        .hold        (hold),
        .advance     (advance),
        .ped_walk    (ped_walk),
        .ped_pending (ped_pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic void chk_int(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic int dwell_of(input logic [1:0] ph);
        int v;
        case (ph)
            PH_RED:  v = RED_C;
            PH_PG:   v = PG_C;
            PH_EG:   v = EG_C;
            default: v = Y_C;
        endcase
        return (v < 1) ? 1 : v;
    endfunction

    // Phase of N cycles: position 0 is the load cycle, 1..d the dwell, d+1..d+W the walk
    always @(negedge clk) begin
        logic       e_adv;
        logic [3:0] e_walk;
        logic [3:0] e_pend;
        logic       serve;
        int         d;
        int         w;
        if (rst) begin
            m_pos  = 0;
            m_walk = -1;
            m_pend = 4'b0;
            chk("reset_advance", 4'(advance), 4'b0);
            chk("reset_ped_walk", ped_walk, 4'b0);
            chk("reset_ped_pending", ped_pending, 4'b0);
            dut_adv_prev = 1'b0;
        end else begin
            d      = dwell_of(phase_type);
            w      = (WALK_C < 1) ? 1 : WALK_C;
            e_adv  = 1'b0;
            e_pend = m_pend;
            e_walk = (m_walk >= 0) ? (4'b0001 << m_walk) : 4'b0;
            serve  = 1'b0;
            if (m_pos == 0) begin
                m_pos = 1;
            end else if (!hold) begin
                if (m_walk < 0) begin
                    if (m_pos < d) begin
                        m_pos++;
                    end else if (phase_type == PH_RED && m_pend[lane]) begin
                        m_walk = int'(lane);
                        serve  = 1'b1;
                        m_pos++;
                    end else begin
                        e_adv = 1'b1;
                        m_pos = 0;
                    end
                end else if (m_pos < d + w) begin
                    m_pos++;
                end else begin
                    e_adv  = 1'b1;
                    m_pos  = 0;
                    m_walk = -1;
                end
            end
            chk("advance", 4'(advance), 4'(e_adv));
            chk("ped_walk", ped_walk, e_walk);
            chk("ped_pending", ped_pending, e_pend);
            m_pend = (m_pend & ~(serve ? (4'b0001 << lane) : 4'b0)) | ped_req;
            dut_adv_prev = advance;
            if (advance) adv_t = cyc;
            if (ped_walk != 4'b0) walk_cycles++;
            walk_or = walk_or | ped_walk;
        end
    end

    // Present one phase until the DUT advances; k=1 is the load cycle
    task automatic run_phase(input logic [1:0] ph, input logic [1:0] ln,
                             input int hold_at, input int hold_len,
                             input int req_at, input logic [3:0] req,
                             output int t);
        bit done;
        done       = 1'b0;
        t          = -1;
        phase_type = ph;
        lane       = ln;
        for (int k = 1; k <= 300; k++) begin
            hold    = (k >= hold_at && k < hold_at + hold_len);
            ped_req = (k == req_at) ? req : 4'b0;
            @(posedge clk);
            #1;
            if (dut_adv_prev) begin
                t    = adv_t;
                done = 1'b1;
                break;
            end
        end
        if (!done) chk_int("advance_timeout", 0, 1);
        hold    = 1'b0;
        ped_req = 4'b0;
    endtask

    initial begin
        int rel;
        int t0, t1, t2, t3, t4, t5, t6, t7, t8, t9, t10;
        rst        = 1'b0;
        phase_type = PH_RED;
        lane       = LANE_NS1;
        ped_req    = 4'b0;
        hold       = 1'b0;
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("lit_reset_advance", 4'(advance), 4'b0);
        chk("lit_reset_pending", ped_pending, 4'b0);
        rst = 1'b0;
        rel = cyc;

        // RED after reset: advance in cycle 3, one cycle wide
        run_phase(PH_RED, LANE_NS1, 0, 0, 0, 4'b0, t0);
        chk_int("first_advance_cycle", t0 - rel + 1, 3);
        chk("advance_one_cycle", 4'(advance), 4'b0);

        // Green/yellow dwell, lane-1 request during lane-0 green, hold in LOAD ignored
        run_phase(PH_PG, LANE_NS1, 0, 0, 5, 4'b0010, t1);
        chk_int("pg_spacing", t1 - t0, 21);
        run_phase(PH_EG, LANE_NS1, 1, 1, 0, 4'b0, t2);
        chk_int("eg_spacing_hold_in_load", t2 - t1, 11);
        run_phase(PH_YELLOW, LANE_NS1, 0, 0, 0, 4'b0, t3);
        chk_int("yellow_spacing", t3 - t2, 5);

        // Lane-1 RED with a pending request: 15-cycle walk
        chk("pending_before_red", ped_pending, 4'b0010);
        walk_cycles = 0;
        walk_or     = 4'b0;
        run_phase(PH_RED, LANE_NS2, 0, 0, 0, 4'b0, t4);
        chk_int("red_walk_spacing", t4 - t3, 18);
        chk_int("walk_cycles", walk_cycles, 15);
        chk("walk_lane", walk_or, 4'b0010);
        chk("pending_after_walk", ped_pending, 4'b0);

        // 7-cycle hold mid-COUNT; requests for lanes 1 and 2
        run_phase(PH_PG, LANE_NS2, 6, 7, 3, 4'b0110, t5);
        chk_int("pg_hold_spacing", t5 - t4, 28);
        run_phase(PH_EG, LANE_NS2, 0, 0, 0, 4'b0, t6);
        chk_int("eg_spacing_2", t6 - t5, 11);
        run_phase(PH_YELLOW, LANE_NS2, 0, 0, 0, 4'b0, t7);
        chk_int("yellow_spacing_2", t7 - t6, 5);

        // 7-cycle hold mid-WALK
        walk_cycles = 0;
        walk_or     = 4'b0;
        run_phase(PH_RED, LANE_NS2, 8, 7, 0, 4'b0, t8);
        chk_int("walk_hold_spacing", t8 - t7, 25);
        chk_int("walk_hold_cycles", walk_cycles, 22);
        chk("walk_hold_lane", walk_or, 4'b0010);
        chk("pending_lane2_kept", ped_pending, 4'b0100);

        // Request on lane 2 in the very cycle lane 2 is served
        walk_or = 4'b0;
        run_phase(PH_RED, LANE_EW1, 0, 0, 3, 4'b0100, t9);
        chk_int("serve_spacing", t9 - t8, 18);
        chk("serve_walk_lane", walk_or, 4'b0100);
        chk("set_wins_pending", ped_pending, 4'b0100);

        // Reset in the middle of a walk
        phase_type = PH_RED;
        lane       = LANE_EW1;
        ped_req    = 4'b1000;
        @(posedge clk);
        #1;
        ped_req = 4'b0;
        repeat (4) @(posedge clk);
        #2;
        chk("pre_reset_walk", ped_walk, 4'b0100);
        chk("pre_reset_pending", ped_pending, 4'b1000);
        rst = 1'b1;
        #1;
        chk("async_reset_walk", ped_walk, 4'b0);
        chk("async_reset_pending", ped_pending, 4'b0);
        chk("async_reset_advance", 4'(advance), 4'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        rel = cyc;
        run_phase(PH_RED, LANE_NS1, 0, 0, 0, 4'b0, t10);
        chk_int("first_advance_after_rerst", t10 - rel + 1, 3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
